shift_scheduler: RTL



---
 rtl/shift_sched_pkg.sv | 13 +
 rtl/rr_arb2.sv | 18 +
 rtl/shift_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift scheduler.
//   state_t     : scheduler FSM states
//   client_id_t : requester index (two clients)
//   DONE_W      : width of the completed-response counter
package shift_sched_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  typedef logic client_id_t;

  localparam int DONE_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter. Holds the priority rule only;
// the pointer itself is stored by the caller.
//   req[1:0] : per-client request
//   ptr      : favoured client when both request
//   gnt[1:0] : one-hot grant, all zero when nothing requests
module rr_arb2
  import shift_sched_pkg::*;
(
  input  logic [1:0] req,
  input  client_id_t ptr,
  output logic [1:0] gnt
);

  // A lone requester wins regardless of ptr; ptr only breaks ties.
  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/shift_scheduler.sv
// Round-robin scheduler sharing one logical-left-shift stage between two
// clients. One request is in flight at a time: IDLE accepts, SHIFT computes
// into the response registers, RESP holds the result until consumed.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-client request handshake
//   req_a0/1, req_s0/1   : per-client operand and shift amount
//   rsp_valid/rsp_ready  : response handshake
//   rsp_y, rsp_id        : shifted result and issuing client
//   done_count           : completed responses, wraps at 256
//   busy                 : high whenever not IDLE
module shift_scheduler
  import shift_sched_pkg::*;
#(
  parameter int N = 6,
  parameter int S = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [N-1:0]      req_a0,
  input  logic [N-1:0]      req_a1,
  input  logic [S-1:0]      req_s0,
  input  logic [S-1:0]      req_s1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_y,
  output client_id_t        rsp_id,
  output logic [DONE_W-1:0] done_count,
  output logic              busy
);

  state_t     state, state_n;
  client_id_t ptr;
  logic [1:0] gnt;
  logic       accept;

  logic [N-1:0] a_q;
  logic [S-1:0] s_q;
  client_id_t   id_q;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // req_ready only depends on state, req_valid and ptr, never on rsp_ready.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) req_ready = gnt;
        accept = |(req_valid & req_ready);
        if (accept) state_n = SHIFT;
      end
      SHIFT: state_n = RESP;
      RESP:  if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b0;
      a_q        <= '0;
      s_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_id     <= 1'b0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q  <= gnt[1] ? req_a1 : req_a0;
            s_q  <= gnt[1] ? req_s1 : req_s0;
            id_q <= client_id_t'(gnt[1]);
          end
        end
        SHIFT: begin
          // Amounts of N or more push every bit out.
          rsp_y     <= (32'(s_q) >= N) ? '0 : (a_q << s_q);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            ptr        <= ~rsp_id;
            done_count <= done_count + DONE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
